mac_valid_tag_pipe: RTL and testbench

//  Parametrised valid/tag shadow pipeline for the MAC datapath. Carries a valid bit, a tag
//  and a mode bit alongside each MAC operation. Full multiply-add ops exit after Stages

---
 rtl/mac_valid_tag_pipe_if.sv | 27 ++
 rtl/mac_valid_tag_pipe.sv | 76 +++++++
 tb/tb_mac_valid_tag_pipe.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mac_valid_tag_pipe_if.sv
// Handshake and status bundle between the MAC issue logic and the valid/tag shadow pipe.
interface mac_valid_tag_pipe_if #(
  parameter int unsigned TagWidth = 8,
  parameter int unsigned CntWidth = 3
);
  logic                ce;
  logic                flush;
  logic                in_valid;
  logic                in_mode;
  logic [TagWidth-1:0] in_tag;
  logic                in_ready;
  logic                out_valid;
  logic                out_mode;
  logic [TagWidth-1:0] out_tag;
  logic [CntWidth-1:0] inflight;
  logic                empty;

  modport master (
    output ce, flush, in_valid, in_mode, in_tag,
    input  in_ready, out_valid, out_mode, out_tag, inflight, empty
  );

  modport slave (
    input  ce, flush, in_valid, in_mode, in_tag,
    output in_ready, out_valid, out_mode, out_tag, inflight, empty
  );
endinterface

// File: rtl/mac_valid_tag_pipe.sv
// Valid/mode/tag shadow pipeline beside the MAC datapath: full ops exit after Stages,
// multiply-only ops after MulStages; with stall, flush, exit-collision interlock and count.
module mac_valid_tag_pipe #(
  parameter int unsigned Stages    = 7,
  parameter int unsigned MulStages = 5,
  parameter int unsigned TagWidth  = 8,
  parameter int unsigned CntWidth  = 3
) (
  input logic                 clk,
  input logic                 aclr,
  mac_valid_tag_pipe_if.slave bus
);
  localparam int unsigned HazStage = Stages - MulStages - 1;
  localparam int unsigned FullExit = Stages - 1;
  localparam int unsigned MulExit  = MulStages - 1;

  logic [Stages-1:0]   v;
  logic [Stages-1:0]   v_nxt;
  logic [Stages-1:0]   m;
  logic [Stages-1:0]   m_nxt;
  logic [TagWidth-1:0] t [Stages];
  logic [CntWidth-1:0] cnt;
  logic                advance;
  logic                hazard;
  logic                accept;
  logic                exit_full;
  logic                exit_mul;

  // A mode-1 op issued now would exit together with the mode-0 entry sitting in HazStage.
  assign advance       = bus.ce & ~bus.flush;
  assign hazard        = v[HazStage] & ~m[HazStage];
  assign bus.in_ready  = advance & ~(bus.in_mode & hazard);
  assign accept        = bus.in_valid & bus.in_ready;
  assign exit_full     = v[FullExit];
  assign exit_mul      = v[MulExit] & m[MulExit];
  assign bus.out_valid = advance & (exit_full | exit_mul);
  assign bus.inflight  = cnt;
  assign bus.empty     = (cnt == '0);

  always_comb begin
    bus.out_tag  = '0;
    bus.out_mode = 1'b0;
    if (exit_full) begin
      bus.out_tag  = t[FullExit];
      bus.out_mode = m[FullExit];
    end else if (exit_mul) begin
      bus.out_tag  = t[MulExit];
      bus.out_mode = 1'b1;
    end
  end

  // Multiply-only entries retire at MulExit and must not continue down the pipe.
  always_comb begin
    v_nxt            = {v[Stages-2:0], accept};
    m_nxt            = {m[Stages-2:0], bus.in_mode};
    v_nxt[MulStages] = v[MulExit] & ~m[MulExit];
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      v   <= '0;
      m   <= '0;
      cnt <= '0;
      for (int unsigned i = 0; i < Stages; i++) t[i] <= '0;
    end else if (bus.flush) begin
      v   <= '0;
      cnt <= '0;
    end else if (bus.ce) begin
      v    <= v_nxt;
      m    <= m_nxt;
      t[0] <= bus.in_tag;
      for (int unsigned i = 1; i < Stages; i++) t[i] <= t[i-1];
      cnt  <= cnt + CntWidth'(accept) - CntWidth'(bus.out_valid);
    end
  end
endmodule

// File: tb/tb_mac_valid_tag_pipe.sv
// Directed bench for mac_valid_tag_pipe (Stages=7, MulStages=5): latency, interlock,
// stall, flush and asynchronous clear, with hand-computed expectations.
module tb_mac_valid_tag_pipe;
  localparam int unsigned TagWidth = 8;
  localparam int unsigned CntWidth = 3;

  logic clk = 1'b0;
  logic aclr;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mac_valid_tag_pipe_if #(.TagWidth(TagWidth), .CntWidth(CntWidth)) bus ();

  mac_valid_tag_pipe #(
    .Stages(7), .MulStages(5), .TagWidth(TagWidth), .CntWidth(CntWidth)
  ) dut (
    .clk (clk),
    .aclr(aclr),
    .bus (bus.slave)
  );

  // Full and multiply-only exits must never coincide.
  always @(negedge clk) begin
    if (!aclr) begin
      total++;
      if (dut.exit_full && dut.exit_mul) begin
        bad++;
        $display("FAIL exit_collision: full=%0b mul=%0b want not both", dut.exit_full, dut.exit_mul);
      end
    end
  end

  task automatic drive(input logic ce, input logic fl, input logic vld, input logic md,
                       input logic [TagWidth-1:0] tg);
    bus.ce = ce; bus.flush = fl; bus.in_valid = vld; bus.in_mode = md; bus.in_tag = tg;
  endtask

  task automatic test_reset();
    aclr = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    #1 aclr = 1'b1;
    #10;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %0b want 1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b want 0", bus.out_valid); end
    total++; if (bus.out_tag !== 8'h00) begin bad++; $display("FAIL rst_out_tag: got %0h want 0", bus.out_tag); end
    total++; if (bus.out_mode !== 1'b0) begin bad++; $display("FAIL rst_out_mode: got %0b want 0", bus.out_mode); end
    total++; if (bus.inflight !== 3'd0) begin bad++; $display("FAIL rst_inflight: got %0d want 0", bus.inflight); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL rst_empty: got %0b want 1", bus.empty); end
    #1 aclr = 1'b0;
  endtask

  task automatic test_single_full();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b0, c == 0, 1'b0, 8'h11);
      @(negedge clk);
      total++;
      if (bus.out_valid !== (c == 7)) begin bad++; $display("FAIL full_out_valid c=%0d: got %0b want %0b", c, bus.out_valid, c == 7); end
      if (c == 7) begin
        total++; if (bus.out_tag !== 8'h11) begin bad++; $display("FAIL full_out_tag: got %0h want 11", bus.out_tag); end
        total++; if (bus.out_mode !== 1'b0) begin bad++; $display("FAIL full_out_mode: got %0b want 0", bus.out_mode); end
      end
      total++;
      if (bus.inflight !== ((c >= 1 && c <= 7) ? 3'd1 : 3'd0)) begin
        bad++; $display("FAIL full_inflight c=%0d: got %0d", c, bus.inflight);
      end
    end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL full_empty: got %0b want 1", bus.empty); end
  endtask

  task automatic test_mul_only();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b0, c == 0, 1'b1, 8'h22);
      @(negedge clk);
      total++;
      if (bus.out_valid !== (c == 5)) begin bad++; $display("FAIL mul_out_valid c=%0d: got %0b want %0b", c, bus.out_valid, c == 5); end
      if (c == 5) begin
        total++; if (bus.out_tag !== 8'h22) begin bad++; $display("FAIL mul_out_tag: got %0h want 22", bus.out_tag); end
        total++; if (bus.out_mode !== 1'b1) begin bad++; $display("FAIL mul_out_mode: got %0b want 1", bus.out_mode); end
      end
    end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL mul_empty: got %0b want 1", bus.empty); end
  endtask

  task automatic test_collision();
    logic [2:0] exp_cnt;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      if (c == 0)                drive(1'b1, 1'b0, 1'b1, 1'b0, 8'hA0);
      else if (c == 2 || c == 3) drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hB0);
      else                       drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      if (c == 2) begin
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL col_blocked: got %0b want 0", bus.in_ready); end
      end
      if (c == 3) begin
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL col_accept: got %0b want 1", bus.in_ready); end
      end
      total++;
      if (bus.out_valid !== (c == 7 || c == 8)) begin bad++; $display("FAIL col_out_valid c=%0d: got %0b", c, bus.out_valid); end
      if (c == 7) begin
        total++; if (bus.out_tag !== 8'hA0 || bus.out_mode !== 1'b0) begin bad++; $display("FAIL col_exit_a0: got %0h/%0b want a0/0", bus.out_tag, bus.out_mode); end
      end
      if (c == 8) begin
        total++; if (bus.out_tag !== 8'hB0 || bus.out_mode !== 1'b1) begin bad++; $display("FAIL col_exit_b0: got %0h/%0b want b0/1", bus.out_tag, bus.out_mode); end
      end
      exp_cnt = (c == 0) ? 3'd0 : (c <= 3) ? 3'd1 : (c <= 7) ? 3'd2 : (c == 8) ? 3'd1 : 3'd0;
      total++;
      if (bus.inflight !== exp_cnt) begin bad++; $display("FAIL col_inflight c=%0d: got %0d want %0d", c, bus.inflight, exp_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    int peak = 0;
    for (int c = 0; c < 22; c++) begin
      @(posedge clk); #1;
      if (c <= 3)                 drive(1'b1, 1'b0, 1'b1, 1'b0, 8'(c));
      else if (c <= 6)            drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
      else if (c <= 12)           drive(1'b1, 1'b0, 1'b1, 1'b0, 8'(c - 3));
      else                        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      if (int'(bus.inflight) > peak) peak = int'(bus.inflight);
      if (c == 5) begin
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_ready: got %0b want 0", bus.in_ready); end
      end
      total++;
      if (bus.out_valid !== (c >= 10 && c <= 19)) begin bad++; $display("FAIL b2b_out_valid c=%0d: got %0b", c, bus.out_valid); end
      if (c >= 10 && c <= 19) begin
        total++; if (bus.out_tag !== 8'(c - 10)) begin bad++; $display("FAIL b2b_out_tag c=%0d: got %0h want %0h", c, bus.out_tag, c - 10); end
      end
      if (c == 10) begin
        total++; if (bus.inflight !== 3'd7) begin bad++; $display("FAIL b2b_inflight_full: got %0d want 7", bus.inflight); end
      end
    end
    total++; if (peak != 7) begin bad++; $display("FAIL b2b_peak: got %0d want 7", peak); end
    total++; if (bus.inflight !== 3'd0) begin bad++; $display("FAIL b2b_drained: got %0d want 0", bus.inflight); end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (c <= 3)       drive(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h40 + c));
      else if (c == 4)  drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h99);
      else              drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      if (c == 4) begin
        total++; if (bus.inflight !== 3'd4) begin bad++; $display("FAIL fl_pre_inflight: got %0d want 4", bus.inflight); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fl_in_ready: got %0b want 0", bus.in_ready); end
      end
      if (c == 5) begin
        total++; if (bus.inflight !== 3'd0 || bus.empty !== 1'b1) begin bad++; $display("FAIL fl_post_inflight: got %0d/%0b want 0/1", bus.inflight, bus.empty); end
      end
      total++;
      if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fl_out_valid c=%0d: got %0b want 0", c, bus.out_valid); end
    end
  endtask

  task automatic test_aclr();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b0, c <= 4, 1'b0, 8'(8'h60 + c));
      @(negedge clk);
    end
    total++; if (bus.inflight !== 3'd5) begin bad++; $display("FAIL ac_pre_inflight: got %0d want 5", bus.inflight); end
    #2 aclr = 1'b1;
    #1;
    total++; if (bus.inflight !== 3'd0 || bus.empty !== 1'b1) begin bad++; $display("FAIL ac_inflight: got %0d/%0b want 0/1", bus.inflight, bus.empty); end
    total++; if (bus.out_valid !== 1'b0 || bus.out_tag !== 8'h00) begin bad++; $display("FAIL ac_out: got %0b/%0h want 0/0", bus.out_valid, bus.out_tag); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL ac_in_ready: got %0b want 1", bus.in_ready); end
    #1 aclr = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ac_out_valid c=%0d: got %0b want 0", c, bus.out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single_full();
    test_mul_only();
    test_collision();
    test_back_to_back();
    test_flush();
    test_aclr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
